alu_ctrl_seq: RTL and testbench

//  Parametrised, registered successor to the 3-bit ALU control decoder. Decodes aluop plus the

---
 rtl/alu_ctrl_pkg.sv | 61 ++++++
 rtl/alu_ctrl_seq_if.sv | 31 +++
 rtl/alu_funct_dec.sv | 57 +++++
 rtl/alu_ctrl_seq.sv | 123 ++++++++++++
 tb/tb_alu_ctrl_seq.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared ALU control codes, funct values and FSM/md encodings
// Purpose: constants and enums used by alu_funct_dec, alu_ctrl_seq and their interface.
// Ports: none (package).
package alu_ctrl_pkg;

  // 4-bit ALU control codes driven to the EX-stage ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SRL  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // MIPS R-type funct field values
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_RTYPE = 2'b10,
    AOP_OR    = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Matches funct[1:0] of the 0110xx group so the decoder can take it directly
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// rtl/alu_ctrl_seq_if.sv - ID/EX to ALU-control bus with mult/div sequencing strobes
// Purpose: bundles the instruction handshake, decoded outputs and HI/LO datapath strobes.
// Signals: flush, valid_in, aluop[1:0], funct[5:0] (from ID/EX); ready, gout[GOUT_W-1:0],
//   gout_vld, illegal, md_start, md_step, md_op[1:0], busy, hilo_we (from alu_ctrl_seq).
interface alu_ctrl_seq_if #(
  parameter int GOUT_W = 4
) ();
  logic              flush;
  logic              valid_in;
  logic              ready;
  logic [1:0]        aluop;
  logic [5:0]        funct;
  logic [GOUT_W-1:0] gout;
  logic              gout_vld;
  logic              illegal;
  logic              md_start;
  logic              md_step;
  logic [1:0]        md_op;
  logic              busy;
  logic              hilo_we;

  modport master (
    output flush, valid_in, aluop, funct,
    input  ready, gout, gout_vld, illegal, md_start, md_step, md_op, busy, hilo_we
  );

  modport slave (
    input  flush, valid_in, aluop, funct,
    output ready, gout, gout_vld, illegal, md_start, md_step, md_op, busy, hilo_we
  );
endinterface

// File: rtl/alu_funct_dec.sv
// rtl/alu_funct_dec.sv - combinational aluop/funct decoder
// Purpose: maps aluop and funct to a 4-bit ALU code, mult/div flag, md op and illegal flag.
// Ports: i_aluop[1:0], i_funct[5:0] in; o_code[3:0], o_is_md, o_md_op, o_illegal out.
module alu_funct_dec
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_MD = 1'b1
) (
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [3:0] o_code,
  output logic       o_is_md,
  output md_op_e     o_md_op,
  output logic       o_illegal
);

  always_comb begin
    o_code    = ALU_ADD;
    o_is_md   = 1'b0;
    o_md_op   = MD_MULT;
    o_illegal = 1'b0;
    case (aluop_e'(i_aluop))
      AOP_ADD: o_code = ALU_ADD;
      AOP_SUB: o_code = ALU_SUB;
      AOP_OR:  o_code = ALU_OR;
      AOP_RTYPE: begin
        case (i_funct)
          F_ADD, F_ADDU:  o_code = ALU_ADD;
          F_SUB, F_SUBU:  o_code = ALU_SUB;
          F_AND:          o_code = ALU_AND;
          F_OR:           o_code = ALU_OR;
          F_XOR:          o_code = ALU_XOR;
          F_NOR:          o_code = ALU_NOR;
          F_SLT:          o_code = ALU_SLT;
          F_SLTU:         o_code = ALU_SLTU;
          F_SLL:          o_code = ALU_SLL;
          F_SRL:          o_code = ALU_SRL;
          F_SRA:          o_code = ALU_SRA;
          // mfhi/mflo route HI/LO through the ALU as a pass-through add
          F_MFHI, F_MFLO: o_code = ALU_ADD;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            // the ALU itself sees an add while the HI/LO unit does the real work
            if (ENABLE_MD) begin
              o_is_md = 1'b1;
              o_md_op = md_op_e'(i_funct[1:0]);
            end else begin
              o_illegal = 1'b1;
            end
          end
          default:        o_illegal = 1'b1;
        endcase
      end
      default: o_code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control decoder with mult/div sequencer
// Purpose: registers the decoded ALU control for EX and runs the IDLE/RUN/DONE sequence
//   that strobes the iterative HI/LO unit for mult/multu/div/divu.
// Ports: clk, rst_n (async active-low); bus (alu_ctrl_seq_if.slave) carrying
//   flush/valid_in/aluop/funct in and ready/gout/gout_vld/illegal/md_*/busy/hilo_we out.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int GOUT_W    = 4,
  parameter int MD_CYCLES = 32,
  parameter bit ENABLE_MD = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  alu_ctrl_seq_if.slave bus
);

  localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [GOUT_W-1:0] r_gout;
  logic              r_gout_vld;
  logic              r_illegal;
  logic              r_md_start;
  md_op_e            r_md_op;

  logic [3:0]        w_code;
  logic              w_is_md;
  md_op_e            w_md_op;
  logic              w_dec_illegal;
  logic              w_ready;
  logic              w_accept;
  logic              w_md_accept;

  alu_funct_dec #(
    .ENABLE_MD (ENABLE_MD)
  ) u_dec (
    .i_aluop   (bus.aluop),
    .i_funct   (bus.funct),
    .o_code    (w_code),
    .o_is_md   (w_is_md),
    .o_md_op   (w_md_op),
    .o_illegal (w_dec_illegal)
  );

  assign w_ready     = (r_state == ST_IDLE);
  assign w_accept    = bus.valid_in & w_ready & ~bus.flush;
  assign w_md_accept = w_accept & w_is_md;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_md_accept) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
        ST_RUN: begin
          // counter is reloaded on every RUN entry, so the decrement never wraps
          if (r_cnt == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gout     <= '0;
      r_gout_vld <= 1'b0;
      r_illegal  <= 1'b0;
      r_md_start <= 1'b0;
      r_md_op    <= MD_MULT;
    end else begin
      // w_accept already excludes flush, so flush clears these pulses too
      r_gout_vld <= w_accept;
      r_illegal  <= w_accept & w_dec_illegal;
      r_md_start <= w_md_accept;
      if (w_accept) begin
        r_gout <= GOUT_W'(w_code);
      end
      if (w_md_accept) begin
        r_md_op <= w_md_op;
      end
    end
  end

  assign bus.ready    = w_ready;
  assign bus.gout     = r_gout;
  assign bus.gout_vld = r_gout_vld;
  assign bus.illegal  = r_illegal;
  assign bus.md_start = r_md_start;
  assign bus.md_op    = r_md_op;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.md_step  = (r_state == ST_RUN);
  // a flush arriving in DONE aborts the op, so the HI/LO write must not land
  assign bus.hilo_we  = (r_state == ST_DONE) & ~bus.flush;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - scoreboard bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.GOUT_W(4)) bus ();
  alu_ctrl_seq_if #(.GOUT_W(4)) bus0 ();

  alu_ctrl_seq #(.GOUT_W(4), .MD_CYCLES(32), .ENABLE_MD(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu_ctrl_seq #(.GOUT_W(4), .MD_CYCLES(32), .ENABLE_MD(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  typedef struct {
    logic [3:0] gout;
    logic       ill;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] md_q[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_step = 0;
  int n_hilo = 0;
  int n_mdstart = 0;
  int n_busy = 0;
  int hilo_cyc = 0;
  int acc_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.gout_vld) begin
        if (exp_q.size() == 0) begin
          check("spurious_gout_vld", int'(bus.gout_vld), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("gout", int'(bus.gout), int'(e.gout));
          check("illegal", int'(bus.illegal), int'(e.ill));
        end
      end else if (bus.illegal) begin
        check("illegal_without_vld", int'(bus.illegal), 0);
      end
      if (bus.md_start) begin
        n_mdstart++;
        if (md_q.size() == 0) begin
          check("spurious_md_start", int'(bus.md_start), 0);
        end else begin
          logic [1:0] m;
          m = md_q.pop_front();
          check("md_op", int'(bus.md_op), int'(m));
        end
      end
      if (bus.md_step) n_step++;
      if (bus.busy) n_busy++;
      if (bus.hilo_we) begin
        n_hilo++;
        hilo_cyc = cyc;
      end
    end
  end

  task automatic clr_counts();
    n_step = 0; n_hilo = 0; n_mdstart = 0; n_busy = 0;
  endtask

  // enters and leaves at posedge+1; holds valid_in until ready, as the caller must
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] eg,
                       input logic ei, input logic md, input logic [1:0] mo);
    int n;
    exp_t e;
    bus.valid_in = 1'b1;
    bus.aluop    = op;
    bus.funct    = fn;
    e.gout = eg;
    e.ill  = ei;
    exp_q.push_back(e);
    if (md) md_q.push_back(mo);
    n = 0;
    while (!bus.ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("issue_ready_timeout", int'(bus.ready), 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] g;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    bus.flush = 0; bus.valid_in = 0; bus.aluop = 0; bus.funct = 0;
    bus0.flush = 0; bus0.valid_in = 0; bus0.aluop = 0; bus0.funct = 0;

    // reset state
    #1 rst_n = 1'b0;
    #10;
    check("rst_gout", int'(bus.gout), 0);
    check("rst_gout_vld", int'(bus.gout_vld), 0);
    check("rst_ready", int'(bus.ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_hilo_we", int'(bus.hilo_we), 0);
    check("rst_md_step", int'(bus.md_step), 0);
    check("rst_md_op", int'(bus.md_op), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // R-type sweep, back-to-back
    vecs = '{
      '{2'b10, 6'b100000, 4'b0010, 1'b0}, '{2'b10, 6'b100001, 4'b0010, 1'b0},
      '{2'b10, 6'b100010, 4'b0110, 1'b0}, '{2'b10, 6'b100011, 4'b0110, 1'b0},
      '{2'b10, 6'b100100, 4'b0000, 1'b0}, '{2'b10, 6'b100101, 4'b0001, 1'b0},
      '{2'b10, 6'b100110, 4'b0100, 1'b0}, '{2'b10, 6'b100111, 4'b1100, 1'b0},
      '{2'b10, 6'b101010, 4'b0111, 1'b0}, '{2'b10, 6'b101011, 4'b1111, 1'b0},
      '{2'b10, 6'b000000, 4'b1000, 1'b0}, '{2'b10, 6'b000010, 4'b0011, 1'b0},
      '{2'b10, 6'b000011, 4'b1001, 1'b0}, '{2'b10, 6'b010000, 4'b0010, 1'b0},
      '{2'b10, 6'b010010, 4'b0010, 1'b0}, '{2'b10, 6'b111111, 4'b0010, 1'b1},
      '{2'b10, 6'b000001, 4'b0010, 1'b1}, '{2'b10, 6'b100100, 4'b0000, 1'b0},
      // non-R-type ignores funct, even mult/div encodings
      '{2'b00, 6'b100010, 4'b0010, 1'b0}, '{2'b00, 6'b011000, 4'b0010, 1'b0},
      '{2'b01, 6'b111111, 4'b0110, 1'b0}, '{2'b01, 6'b100100, 4'b0110, 1'b0},
      '{2'b11, 6'b000000, 4'b0001, 1'b0}, '{2'b11, 6'b011010, 4'b0001, 1'b0}
    };
    clr_counts();
    foreach (vecs[i]) issue(vecs[i].op, vecs[i].fn, vecs[i].g, vecs[i].ill, 1'b0, 2'b00);
    idle(2);
    check("non_md_busy_cycles", n_busy, 0);
    check("non_md_md_start", n_mdstart, 0);
    // no accept: gout holds the last value (or code) with gout_vld low
    check("hold_gout", int'(bus.gout), 1);
    check("hold_gout_vld", int'(bus.gout_vld), 0);

    // div: 32 steps, one hilo_we, ready back 34 cycles after accept
    clr_counts();
    issue(2'b10, 6'b011010, 4'b0010, 1'b0, 1'b1, 2'b10);
    n = 0;
    while (!bus.ready && n < 100) begin @(posedge clk); #1; n++; end
    check("div_ready_after_accept", n + 1, 34);
    check("div_md_steps", n_step, 32);
    check("div_hilo_we", n_hilo, 1);
    check("div_md_start", n_mdstart, 1);

    // flush on 10th RUN cycle, valid_in held during RUN must be ignored
    clr_counts();
    issue(2'b10, 6'b011000, 4'b0010, 1'b0, 1'b1, 2'b00);
    bus.valid_in = 1'b1; bus.aluop = 2'b10; bus.funct = 6'b100100;
    idle(9);
    bus.valid_in = 1'b0;
    bus.flush = 1'b1;
    idle(1);
    bus.flush = 1'b0;
    check("flush_ready", int'(bus.ready), 1);
    check("flush_busy", int'(bus.busy), 0);
    check("flush_md_steps", n_step, 10);
    check("flush_hilo_we", n_hilo, 0);
    // flush with valid_in in IDLE accepts nothing
    bus.valid_in = 1'b1; bus.funct = 6'b100101; bus.flush = 1'b1;
    idle(1);
    bus.valid_in = 1'b0; bus.flush = 1'b0;
    check("flush_idle_gout_vld", int'(bus.gout_vld), 0);
    check("flush_idle_gout_hold", int'(bus.gout), 2);
    check("flush_idle_ready", int'(bus.ready), 1);

    // flush in DONE suppresses hilo_we
    clr_counts();
    issue(2'b10, 6'b011011, 4'b0010, 1'b0, 1'b1, 2'b11);
    idle(32);
    check("done_busy", int'(bus.busy), 1);
    check("done_hilo_we_before_flush", int'(bus.hilo_we), 1);
    bus.flush = 1'b1;
    #1;
    check("done_hilo_we_flushed", int'(bus.hilo_we), 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("done_flush_steps", n_step, 32);
    check("done_flush_hilo_count", n_hilo, 0);
    check("done_flush_ready", int'(bus.ready), 1);

    // back-to-back mult then add
    clr_counts();
    issue(2'b10, 6'b011001, 4'b0010, 1'b0, 1'b1, 2'b01);
    issue(2'b10, 6'b100010, 4'b0110, 1'b0, 1'b0, 2'b00);
    check("b2b_accept_after_hilo", acc_cyc - hilo_cyc, 1);
    check("b2b_hilo_count", n_hilo, 1);
    check("b2b_steps", n_step, 32);
    issue(2'b10, 6'b011000, 4'b0010, 1'b0, 1'b1, 2'b00);
    check("b2b_md_after_add", int'(bus.busy), 1);
    idle(40);
    check("b2b_hilo_count2", n_hilo, 2);

    // ENABLE_MD=0: mult decodes as illegal, never busy
    bus0.valid_in = 1'b1; bus0.aluop = 2'b10; bus0.funct = 6'b011000;
    idle(1);
    bus0.valid_in = 1'b0;
    check("nomd_gout", int'(bus0.gout), 2);
    check("nomd_illegal", int'(bus0.illegal), 1);
    check("nomd_gout_vld", int'(bus0.gout_vld), 1);
    check("nomd_md_start", int'(bus0.md_start), 0);
    idle(1);
    check("nomd_busy", int'(bus0.busy), 0);
    check("nomd_ready", int'(bus0.ready), 1);

    // async reset mid-RUN
    clr_counts();
    issue(2'b10, 6'b011001, 4'b0010, 1'b0, 1'b1, 2'b01);
    idle(4);
    #3 rst_n = 1'b0;
    #1;
    check("arst_gout", int'(bus.gout), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_ready", int'(bus.ready), 1);
    check("arst_hilo_we", int'(bus.hilo_we), 0);
    check("arst_md_step", int'(bus.md_step), 0);
    check("arst_md_op", int'(bus.md_op), 0);
    idle(2);
    rst_n = 1'b1;
    idle(40);
    check("arst_no_hilo", n_hilo, 0);
    check("arst_busy_after", int'(bus.busy), 0);

    check("exp_q_drained", exp_q.size(), 0);
    check("md_q_drained", md_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
